// File: rtl/ci_pkg.sv
`default_nettype none
// ============================================================================
// ci_pkg -- shared types and defaults for the custom-instruction requester
// Revision 1.0
// ============================================================================
package ci_pkg;

    localparam int CI_DATA_W          = 32;
    localparam int CI_TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RECOVER = 3'd3,
        ST_RESPOND = 3'd4
    } ci_req_state_t;

endpackage
`default_nettype wire

// File: rtl/ci_watchdog.sv
`default_nettype none
// ============================================================================
// ci_watchdog -- saturating cycle counter that flags the last allowed WAIT cycle
// Revision 1.0
// ============================================================================
module ci_watchdog
    import ci_pkg::*;
#(
    parameter int TIMEOUT = CI_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(TIMEOUT);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // This increment brings the count to TIMEOUT, so the requester leaves WAIT now.
    assign expired = enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/ci_requester.sv
`default_nettype none
// ============================================================================
// ci_requester -- initiator for the multi-cycle custom-instruction handshake
// Revision 1.0
// ============================================================================
module ci_requester
    import ci_pkg::*;
#(
    parameter int TIMEOUT = CI_TIMEOUT_DEFAULT,
    parameter int DATA_W  = CI_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_timeout,
    output logic              ci_clk_en,
    output logic              ci_start,
    output logic              ci_reset,
    output logic [DATA_W-1:0] ci_dataa,
    output logic [DATA_W-1:0] ci_datab,
    input  logic [DATA_W-1:0] ci_result,
    input  logic              ci_done
);

    ci_req_state_t     r_state;
    ci_req_state_t     w_state_nxt;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_timeout;
    logic              w_wd_clear;
    logic              w_wd_enable;
    logic              w_wd_expired;

    assign w_wd_clear  = (r_state == ST_ISSUE);
    assign w_wd_enable = (r_state == ST_WAIT) && !ci_done;

    ci_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_wd_clear),
        .enable  (w_wd_enable),
        .expired (w_wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        ci_start    = 1'b0;
        ci_clk_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            // ci_done is not looked at here: it may still be high from the last job.
            ST_ISSUE: begin
                ci_start    = 1'b1;
                ci_clk_en   = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                ci_clk_en = 1'b1;
                if (ci_done) begin
                    w_state_nxt = ST_RESPOND;
                end else if (w_wd_expired) begin
                    w_state_nxt = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                w_state_nxt = ST_RESPOND;
            end
            ST_RESPOND: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Reset silences every handshake output in the cycle it is asserted.
        if (reset) begin
            req_ready = 1'b0;
            rsp_valid = 1'b0;
            ci_start  = 1'b0;
            ci_clk_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && req_valid) begin
                r_op_a <= req_a;
                r_op_b <= req_b;
            end
            if ((r_state == ST_WAIT) && ci_done) begin
                r_rsp_data    <= ci_result;
                r_rsp_timeout <= 1'b0;
            end else if (r_state == ST_RECOVER) begin
                r_rsp_data    <= '0;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign ci_reset    = reset || (r_state == ST_RECOVER);
    assign rsp_data    = reset ? '0 : r_rsp_data;
    assign rsp_timeout = !reset && r_rsp_timeout;
    assign ci_dataa    = reset ? '0 : r_op_a;
    assign ci_datab    = reset ? '0 : r_op_b;

endmodule
`default_nettype wire

// File: tb/tb_ci_requester.sv
`default_nettype none
// ============================================================================
// tb_ci_requester -- directed bench with a timestamp-based reference model
// Revision 1.0
// ============================================================================
module tb_ci_requester;

    localparam int TO = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] req_a = '0;
    logic [DW-1:0] req_b = '0;
    logic          req_ready, rsp_valid, rsp_timeout;
    logic          ci_clk_en, ci_start, ci_reset, ci_done;
    logic [DW-1:0] rsp_data, ci_dataa, ci_datab, ci_result;

    // slave model (remainder unit) state
    logic          sl_done = 1'b0;
    logic          force_done = 1'b0;
    logic [DW-1:0] sl_result = '0;
    logic [DW-1:0] sl_a = '0;
    logic [DW-1:0] sl_b = '0;
    bit            sl_busy = 0;
    bit            sl_never = 0;
    int            sl_lat = 5;
    int            sl_cnt = 0;

    assign ci_done   = sl_done | force_done;
    assign ci_result = sl_result;

    ci_requester #(.TIMEOUT(TO), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .ci_clk_en   (ci_clk_en),
        .ci_start    (ci_start),
        .ci_reset    (ci_reset),
        .ci_dataa    (ci_dataa),
        .ci_datab    (ci_datab),
        .ci_result   (ci_result),
        .ci_done     (ci_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    int n_start = 0;
    int n_creset = 0;
    int n_rvalid = 0;
    int last_cr = -1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    always @(posedge clk) begin
        #2;
        if (ci_reset) begin
            sl_busy = 0;
            sl_done = 1'b0;
        end else begin
            sl_done = 1'b0;
            if (ci_start) begin
                if (!sl_never) begin
                    sl_busy = 1;
                    sl_cnt  = sl_lat;
                    sl_a    = ci_dataa;
                    sl_b    = ci_datab;
                end
            end else if (sl_busy) begin
                sl_cnt--;
                if (sl_cnt == 0) begin
                    sl_busy   = 0;
                    sl_done   = 1'b1;
                    sl_result = sl_a % sl_b;
                end
            end
        end
    end

    // Reference model: one transaction described by its accept cycle and response cycle.
    bit            m_busy = 0;
    int            m_acc = 0;
    int            m_rsp = -1;
    bit            m_to = 0;
    logic [DW-1:0] m_a = '0;
    logic [DW-1:0] m_b = '0;
    logic [DW-1:0] m_data = '0;

    always @(negedge clk) begin
        logic          e_rr, e_rv, e_st, e_en, e_cr, e_to, e_ops;
        logic [DW-1:0] e_data;
        e_rr = 0; e_rv = 0; e_st = 0; e_en = 0; e_cr = 0; e_to = 0; e_ops = 0; e_data = '0;
        if (reset) begin
            e_cr = 1;
        end else if (!m_busy) begin
            e_rr = 1;
        end else if (cyc == m_acc + 1) begin
            e_st = 1; e_en = 1; e_ops = 1;
        end else if (m_rsp < 0 || cyc < m_rsp) begin
            if (m_rsp >= 0 && m_to && cyc == m_rsp - 1) e_cr = 1;
            else begin e_en = 1; e_ops = 1; end
        end else begin
            e_rv = 1; e_data = m_data; e_to = m_to;
        end

        check("req_ready", 32'(req_ready), 32'(e_rr));
        check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        check("ci_start",  32'(ci_start),  32'(e_st));
        check("ci_clk_en", 32'(ci_clk_en), 32'(e_en));
        check("ci_reset",  32'(ci_reset),  32'(e_cr));
        if (e_rv || reset) begin
            check("rsp_data",    rsp_data,           e_data);
            check("rsp_timeout", 32'(rsp_timeout),   32'(e_to));
        end
        if (reset) begin
            check("ci_dataa_rst", ci_dataa, '0);
            check("ci_datab_rst", ci_datab, '0);
        end else if (e_ops) begin
            check("ci_dataa", ci_dataa, m_a);
            check("ci_datab", ci_datab, m_b);
        end

        if (!reset) begin
            if (ci_start)  n_start++;
            if (ci_reset)  begin n_creset++; last_cr = cyc; end
            if (rsp_valid) n_rvalid++;
        end

        if (reset) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1; m_acc = cyc; m_rsp = -1; m_to = 0;
                m_a = req_a; m_b = req_b;
            end
        end else if (m_rsp < 0) begin
            if (cyc >= m_acc + 2 && ci_done) begin
                m_rsp = cyc + 1; m_to = 0; m_data = m_a % m_b;
            end else if (cyc == m_acc + 1 + TO) begin
                m_rsp = cyc + 2; m_to = 1; m_data = '0;
            end
        end else if (cyc >= m_rsp && rsp_ready) begin
            m_busy = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit stale,
                        output int t_acc);
        int g = 0;
        req_a = a; req_b = b; req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && g < 50) begin @(negedge clk); g++; end
        if (!req_ready) check("req_accept_bound", 32'(req_ready), 32'd1);
        tick();
        t_acc = cyc - 1;
        req_valid = 1'b0;
        if (stale) begin
            force_done = 1'b1;
            tick();
            force_done = 1'b0;
        end
    endtask

    task automatic get_rsp(input int hold, output int t_v, output logic [DW-1:0] d, output logic to);
        int g = 0;
        @(negedge clk);
        while (!rsp_valid && g < 200) begin @(negedge clk); g++; end
        check("rsp_valid_bound", 32'(rsp_valid), 32'd1);
        t_v = cyc; d = rsp_data; to = rsp_timeout;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_rsp_data", rsp_data, d);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        check("ready_after_hs", 32'(req_ready), 32'd1);
        tick();
    endtask

    initial begin
        int t, tv, c0, s0, v0;
        logic [DW-1:0] d;
        logic to;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_ci_reset",  32'(ci_reset),  32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);
        tick();

        // normal division 100 % 7
        sl_lat = 5; s0 = n_start;
        send(32'd100, 32'd7, 0, t);
        get_rsp(0, tv, d, to);
        check("div_data", d, 32'd2);
        check("div_timeout", 32'(to), 32'd0);
        check("div_latency", 32'(tv - t), 32'd7);
        check("div_start_cycles", 32'(n_start - s0), 32'd1);

        // timeout, then recovery with 9 % 4
        sl_never = 1; c0 = n_creset;
        send(32'd77, 32'd3, 0, t);
        get_rsp(0, tv, d, to);
        check("to_data", d, 32'd0);
        check("to_flag", 32'(to), 32'd1);
        check("to_rsp_cycle", 32'(tv - t), 32'd19);
        check("to_reset_cycle", 32'(last_cr - t), 32'd18);
        check("to_reset_pulses", 32'(n_creset - c0), 32'd1);
        sl_never = 0;
        send(32'd9, 32'd4, 0, t);
        get_rsp(0, tv, d, to);
        check("after_to_data", d, 32'd1);

        // backpressure: 1234 % 10
        send(32'd1234, 32'd10, 0, t);
        get_rsp(10, tv, d, to);
        check("bp_data", d, 32'd4);

        // stale done during ISSUE: 200 % 9
        send(32'd200, 32'd9, 1, t);
        get_rsp(0, tv, d, to);
        check("stale_data", d, 32'd2);
        check("stale_latency", 32'(tv - t), 32'd7);

        // done coincident with watchdog limit: 1000 % 7
        sl_lat = TO; c0 = n_creset;
        send(32'd1000, 32'd7, 0, t);
        get_rsp(0, tv, d, to);
        check("coin_data", d, 32'd6);
        check("coin_timeout", 32'(to), 32'd0);
        check("coin_latency", 32'(tv - t), 32'd18);
        check("coin_no_reset", 32'(n_creset - c0), 32'd0);

        // reset pulse in the middle of WAIT
        sl_lat = 20; v0 = n_rvalid;
        send(32'd500, 32'd3, 0, t);
        repeat (3) tick();
        reset = 1'b1;
        @(negedge clk);
        check("midrst_ci_reset", 32'(ci_reset), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready_next", 32'(req_ready), 32'd1);
        repeat (30) tick();
        check("midrst_no_rsp", 32'(n_rvalid - v0), 32'd0);
        sl_lat = 5;
        send(32'd50, 32'd8, 0, t);
        get_rsp(0, tv, d, to);
        check("fresh_data", d, 32'd2);
        check("fresh_timeout", 32'(to), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit: run did not finish, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
`default_nettype wire
